pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Programmable square-wave pulse generator that drives a single pin with a burst of N full pulses, or a continuous train, at a programmed half-period measured in clock cycles. It is the transmit-side counterpart of the MiniProjectTop edge/frequency counter. It produces known pulse counts per measurement window on the line that feeds the counter's JA1 input, for loopback and bench stimulus on the board.

## Interface
- WIDTH, 16, width of half-period, pulse-count and sent-count fields
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; dominates all other inputs
- start  input  1  one-cycle request; accepted only in IDLE
- cont  input  1  sampled with start: 1 = continuous train, 0 = burst of `n_pulses`
- stop  input  1  ends a continuous train cleanly; ignored in burst mode and in IDLE
- half_period  input  WIDTH  clock cycles per high phase and per low phase, sampled at start
- n_pulses  input  WIDTH  pulses in the burst, sampled at start
- pulse_out  output  1  generated waveform, registered
- busy  output  1  high while a train is in progress
- done  output  1  one-cycle strobe when a train completes
- sent  output  WIDTH  count of rising edges emitted in the current or last train

## Operation
- States:
  - IDLE: waiting for start.
  - HIGH: pulse_out driving 1.
  - LOW: pulse_out driving 0.
  - FIN: one cycle; raises done, then returns to IDLE.
- IDLE + start:
  - Latch half_period, n_pulses and cont.
  - Clear sent.
  - A latched half_period of 0 is treated as 1.
  - If n_pulses == 0 and cont == 0, go directly to FIN. No edge is emitted.
  - Otherwise go to HIGH.
- Phase counter: reloads to half-period − 1 on entry to HIGH and to LOW, and decrements each cycle. The phase ends when it reaches 0.
- HIGH:
  - `sent` increments (wraps at 2^WIDTH) in the first HIGH cycle.
  - At phase end, go to LOW.
- LOW, at phase end, the next state is decided as follows:
  - Burst mode: if sent == latched n_pulses, go to FIN; else go to HIGH.
  - Continuous mode: if a stop request is pending, go to FIN; else go to HIGH.
- stop:
  - Any stop pulse seen during HIGH or LOW sets a pending flag.
  - Termination always happens at the end of a LOW phase. No runt pulses are produced.
  - The pending flag clears in IDLE.
- start while busy is ignored. A new train requires a new start in IDLE.
- The input ports are not used after the start cycle. Changing them mid-train has no effect.
- reset, from any state, including mid-pulse:
  - state = IDLE, pulse_out = 0, busy = 0, done = 0, sent = 0.
  - Latched fields and the stop flag are cleared.

## Timing
- Reset values: pulse_out 0, busy 0, done 0, sent 0.
- Let start be sampled at edge t. pulse_out = 1 and busy = 1 from cycle t+1.
- Each pulse lasts 2·H cycles: H high followed by H low, where H is the effective half-period.
- Burst of N ≥ 1:
  - busy is high for cycles t+1 … t+2HN.
  - pulse_out = 0 and done = 1 at cycle t+2HN+1. busy = 0 in the same cycle.
  - The design is back in IDLE at t+2HN+2. The earliest next start is sampled in that cycle.
- N == 0 burst: busy stays 0. done = 1 at t+1, pulse_out stays 0, sent = 0.
- done is exactly one cycle wide. sent holds its final value until the next accepted start.
- Continuous mode with stop sampled at cycle s:
  - The current pulse completes its LOW phase.
  - done is asserted in the cycle after that LOW phase ends.
- reset and start in the same cycle: reset wins and start is lost.

## Test plan
- Reset mid-HIGH of a burst with H=4, N=5: in the cycle after reset, pulse_out=0, busy=0, done=0, sent=0. No further edges occur.
- Burst with half_period=1, n_pulses=3, start at cycle t:
  - pulse_out reads 1,0,1,0,1,0 over t+1…t+6.
  - done=1 and busy=0 at t+7. sent=3.
- half_period=0, n_pulses=2: behaves identically to H=1 (4 busy cycles, done at t+5).
- n_pulses=0, cont=0: done at t+1, no rising edge, busy never high.
- Continuous train with H=3; stop pulsed during the 4th HIGH phase:
  - Exactly 4 rising edges, sent=4.
  - Last LOW phase is a full 3 cycles. done follows it.
  - A start pulsed mid-train is ignored.
- Loopback into MiniProjectTop JA1 with H=200, N=123 inside one counter window: the counter reports 123.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Square-wave burst/continuous pulse generator: emits N full pulses (or a train
// until stopped) at a programmable half-period, with busy/done/sent status.
module pulse_train_gen #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_cont,
  input  logic             i_stop,
  input  logic [WIDTH-1:0] i_half_period,
  input  logic [WIDTH-1:0] i_n_pulses,
  output logic             o_pulse_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sent
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hp, r_np, r_phase, r_sent;
  logic             r_cont, r_stop_pend;
  logic             r_pulse, r_busy, r_done;

  logic [WIDTH-1:0] w_hp_eff, w_phase_nxt, w_sent_nxt;
  logic             w_phase_end, w_last;

  assign w_hp_eff    = (i_half_period == '0) ? WIDTH'(1) : i_half_period;
  assign w_phase_end = (r_phase == '0);
  // A stop arriving in the final LOW cycle still ends the train on this pulse.
  assign w_last      = r_cont ? (r_stop_pend | i_stop) : (r_sent == r_np);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_sent_nxt  = r_sent;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_sent_nxt = '0;
          if (i_n_pulses == '0 && !i_cont) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_HIGH;
            w_phase_nxt = w_hp_eff - WIDTH'(1);
            w_sent_nxt  = WIDTH'(1);
          end
        end
      end
      S_HIGH: begin
        w_phase_nxt = r_phase - WIDTH'(1);
        if (w_phase_end) begin
          w_state_nxt = S_LOW;
          w_phase_nxt = r_hp - WIDTH'(1);
        end
      end
      S_LOW: begin
        w_phase_nxt = r_phase - WIDTH'(1);
        if (w_phase_end) begin
          if (w_last) begin
            w_state_nxt = S_FIN;
            w_phase_nxt = '0;
          end else begin
            w_state_nxt = S_HIGH;
            w_phase_nxt = r_hp - WIDTH'(1);
            // sent tracks rising edges as they appear on the pin
            w_sent_nxt  = r_sent + WIDTH'(1);
          end
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_sent      <= '0;
      r_hp        <= '0;
      r_np        <= '0;
      r_cont      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_pulse     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_sent  <= w_sent_nxt;
      r_pulse <= (w_state_nxt == S_HIGH);
      r_busy  <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_LOW);
      r_done  <= (w_state_nxt == S_FIN);
      if (r_state == S_IDLE && i_start) begin
        r_hp   <= w_hp_eff;
        r_np   <= i_n_pulses;
        r_cont <= i_cont;
      end
      if (r_state == S_IDLE)
        r_stop_pend <= 1'b0;
      else if ((r_state == S_HIGH || r_state == S_LOW) && r_cont && i_stop)
        r_stop_pend <= 1'b1;
    end
  end

  assign o_pulse_out = r_pulse;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sent      = r_sent;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: timeline model of each accepted train plus
// directed scenarios with literal expectations.
module tb_pulse_train_gen;
  localparam int WIDTH = 16;
  localparam longint INF = 64'd1 << 40;

  logic             clk = 1'b0;
  logic             reset, start, cont, stop;
  logic [WIDTH-1:0] half_period, n_pulses;
  logic             pulse_out, busy, done;
  logic [WIDTH-1:0] sent;

  pulse_train_gen #(.WIDTH(WIDTH)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_cont(cont), .i_stop(stop),
    .i_half_period(half_period), .i_n_pulses(n_pulses),
    .o_pulse_out(pulse_out), .o_busy(busy), .o_done(done), .o_sent(sent)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a train accepted at cycle t0 with half-period H is busy over
  // t0+1..tend, high in the first H cycles of each 2H window, done at tend+1.
  longint cyc = 0;
  bit     m_active = 0;
  bit     m_cont;
  longint t0, tend, mh;
  longint msent = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0;
      msent    = 0;
    end else begin
      if (m_active && m_cont && tend == INF && stop && cyc >= t0 + 1) begin
        longint p;
        p     = (cyc - t0 - 1) / (2 * mh);
        tend  = t0 + 2 * mh * (p + 1);
        msent = p + 1;
      end
      if ((!m_active || cyc >= tend + 2) && start) begin
        m_active = 1;
        t0       = cyc;
        mh       = (half_period == 0) ? 1 : longint'(half_period);
        m_cont   = cont;
        tend     = cont ? INF : t0 + 2 * mh * longint'(n_pulses);
        msent    = cont ? 0 : longint'(n_pulses);
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      bit eb, ep, ed;
      eb = m_active && cyc >= t0 + 1 && cyc <= tend;
      ep = eb && (((cyc - t0 - 1) % (2 * mh)) < mh);
      ed = m_active && cyc == tend + 1;
      chk("model_busy", {31'd0, busy}, {31'd0, eb});
      chk("model_pulse", {31'd0, pulse_out}, {31'd0, ep});
      chk("model_done", {31'd0, done}, {31'd0, ed});
      if (!eb) chk("model_sent", {16'd0, sent}, 32'(msent));
    end
  end

  int  rise_cnt = 0;
  logic prev_p = 1'b0;
  always @(negedge clk) begin
    if (pulse_out === 1'b1 && prev_p === 1'b0) rise_cnt++;
    prev_p = pulse_out;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start; returns the cycle in which start was sampled.
  task automatic go(input int hp, input int n, input bit c, output longint t);
    half_period = WIDTH'(hp);
    n_pulses    = WIDTH'(n);
    cont        = c;
    start       = 1'b1;
    t           = cyc;
    cycles(1);
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output longint at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        at = cyc;
        break;
      end
    end
    ntests++;
    if (at < 0) begin
      nfail++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  initial begin
    longint t, td;
    logic [5:0] wave;
    int cnt;
    reset = 1'b1; start = 1'b0; cont = 1'b0; stop = 1'b0;
    half_period = '0; n_pulses = '0;
    cycles(3);
    @(negedge clk);
    chk("reset_outs", {pulse_out, busy, done, 13'd0, sent}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cycles(2);

    // H=1, N=3: 101010 then done at t+7
    go(1, 3, 0, t);
    for (int k = 5; k >= 0; k--) begin
      @(negedge clk);
      wave[k] = pulse_out;
    end
    chk("h1n3_wave", {26'd0, wave}, 32'b101010);
    @(negedge clk);
    chk("h1n3_done", {30'd0, done, busy}, 32'b10);
    chk("h1n3_sent", {16'd0, sent}, 32'd3);
    chk("h1n3_t", 32'(cyc - t), 32'd7);
    cycles(2);

    // H=0 behaves as H=1: 4 busy cycles, done at t+5
    go(0, 2, 0, t);
    cnt = 0;
    td  = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
      if (done === 1'b1) td = cyc - t;
    end
    chk("h0_busy_cnt", 32'(cnt), 32'd4);
    chk("h0_done_t", 32'(td), 32'd5);

    // N=0 burst: done at t+1, no edge, never busy
    cycles(1);
    rise_cnt = 0;
    go(3, 0, 0, t);
    @(negedge clk);
    chk("n0_done", {29'd0, done, busy, pulse_out}, 32'b100);
    cycles(5);
    chk("n0_edges", 32'(rise_cnt), 32'd0);

    // Continuous H=3, start ignored mid-train, stop in 4th HIGH (t+19..t+21)
    rise_cnt = 0;
    go(3, 0, 1, t);
    cycles(3);
    half_period = 16'd7; n_pulses = 16'd9; cont = 1'b0; start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(14);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    wait_done("cont_done", 60, td);
    chk("cont_done_t", 32'(td - t), 32'd25);
    chk("cont_edges", 32'(rise_cnt), 32'd4);
    chk("cont_sent", {16'd0, sent}, 32'd4);
    cycles(2);

    // Burst ignores stop; inputs changed mid-train; back-to-back restart
    go(5, 4, 0, t);
    half_period = 16'd1; n_pulses = 16'd1; cont = 1'b1;
    cycles(10);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    wait_done("burst_done", 80, td);
    chk("burst_done_t", 32'(td - t), 32'd41);
    chk("burst_sent", {16'd0, sent}, 32'd4);
    cycles(1);
    go(2, 2, 0, t);
    wait_done("b2b_done", 40, td);
    chk("b2b_done_t", 32'(td - t), 32'd9);
    cycles(2);

    // Reset mid-HIGH of H=4 N=5
    go(4, 5, 0, t);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid", {pulse_out, busy, done, 13'd0, sent}, 32'd0);
    rise_cnt = 0;
    cycles(50);
    chk("rst_no_edges", 32'(rise_cnt), 32'd0);

    // reset and start together: start lost
    reset = 1'b1;
    go(2, 3, 0, t);
    reset = 1'b0;
    cycles(3);
    @(negedge clk);
    chk("rst_start", {30'd0, busy, pulse_out}, 32'd0);
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
